// File: rtl/wb_regfile_unit_pkg.sv
// Shared widths, register-file constants and write-back types for the ARM write-back stage.
package wb_regfile_unit_pkg;

  localparam int unsigned REGISTER_LEN        = 32;
  localparam int unsigned REGFILE_ADDRESS_LEN = 4;
  localparam int unsigned STATUS_LEN          = 4;
  localparam int unsigned REGFILE_DEPTH       = 15;

  typedef logic [REGISTER_LEN-1:0]        word_t;
  typedef logic [REGFILE_ADDRESS_LEN-1:0] reg_addr_t;
  typedef logic [STATUS_LEN-1:0]          status_t;

  // R15 is the PC; it lives in fetch, not in this array.
  localparam reg_addr_t PC_REG_INDEX = 4'd15;

  typedef struct packed {
    logic      wb_en;
    logic      r_en;
    word_t     alu_result;
    word_t     mem_data;
    reg_addr_t dest;
  } mem_wb_t;

  // Architectural reset contents: R[i] = i.
  function automatic word_t reg_reset_value(input int unsigned idx);
    return word_t'(idx);
  endfunction

endpackage

// File: rtl/wb_regfile_unit_if.sv
// MEM-stage, decode-read, status and write-back signals of the write-back unit.
interface wb_regfile_unit_if;
  import wb_regfile_unit_pkg::*;

  logic      freeze;
  logic      mem_wb_en_in;
  logic      mem_r_en_in;
  word_t     alu_result_in;
  word_t     mem_data_in;
  reg_addr_t dest_in;

  reg_addr_t rd_addr1;
  reg_addr_t rd_addr2;
  word_t     rd_data1;
  word_t     rd_data2;

  logic      status_we;
  status_t   status_in;
  status_t   status_out;

  logic      wb_en_out;
  reg_addr_t wb_dest_out;
  word_t     wb_value_out;

  modport slave (
    input  freeze, mem_wb_en_in, mem_r_en_in, alu_result_in, mem_data_in, dest_in,
    input  rd_addr1, rd_addr2, status_we, status_in,
    output rd_data1, rd_data2, status_out, wb_en_out, wb_dest_out, wb_value_out
  );

  modport master (
    output freeze, mem_wb_en_in, mem_r_en_in, alu_result_in, mem_data_in, dest_in,
    output rd_addr1, rd_addr2, status_we, status_in,
    input  rd_data1, rd_data2, status_out, wb_en_out, wb_dest_out, wb_value_out
  );

endinterface

// File: rtl/register_file.sv
// 15-entry register file with one write port and two combinational read ports with
// write-through bypass, so decode sees a value in the cycle it is committed.
module register_file
  import wb_regfile_unit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      wb_en_i,
  input  reg_addr_t wb_dest_i,
  input  word_t     wb_value_i,
  input  reg_addr_t rd_addr1_i,
  input  reg_addr_t rd_addr2_i,
  output word_t     rd_data1_o,
  output word_t     rd_data2_o
);

  word_t regs_q [REGFILE_DEPTH];
  logic  wr_valid;

  assign wr_valid = wb_en_i && (wb_dest_i != PC_REG_INDEX);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < REGFILE_DEPTH; i++) begin
        regs_q[i] <= reg_reset_value(i);
      end
    end else if (wr_valid) begin
      regs_q[wb_dest_i] <= wb_value_i;
    end
  end

  // Address 15 must win over the bypass, since a discarded R15 write can sit in WB.
  always_comb begin
    rd_data1_o = '0;
    if (rd_addr1_i == PC_REG_INDEX) begin
      rd_data1_o = '0;
    end else if (wb_en_i && (rd_addr1_i == wb_dest_i)) begin
      rd_data1_o = wb_value_i;
    end else begin
      rd_data1_o = regs_q[rd_addr1_i];
    end
  end

  always_comb begin
    rd_data2_o = '0;
    if (rd_addr2_i == PC_REG_INDEX) begin
      rd_data2_o = '0;
    end else if (wb_en_i && (rd_addr2_i == wb_dest_i)) begin
      rd_data2_o = wb_value_i;
    end else begin
      rd_data2_o = regs_q[rd_addr2_i];
    end
  end

endmodule

// File: rtl/wb_regfile_unit.sv
// Write-back stage: MEM/WB register, ALU/load value select, NZCV status register and
// the register file that decode reads.
module wb_regfile_unit
  import wb_regfile_unit_pkg::*;
(
  input logic               clk,
  input logic               rst,
  wb_regfile_unit_if.slave  bus
);

  mem_wb_t mem_wb_q, mem_wb_d;
  status_t status_q, status_d;
  word_t   wb_value;

  always_comb begin
    mem_wb_d = mem_wb_q;
    if (!bus.freeze) begin
      mem_wb_d.wb_en      = bus.mem_wb_en_in;
      mem_wb_d.r_en       = bus.mem_r_en_in;
      mem_wb_d.alu_result = bus.alu_result_in;
      mem_wb_d.mem_data   = bus.mem_data_in;
      mem_wb_d.dest       = bus.dest_in;
    end
  end

  // A frozen status write is dropped; EXE re-presents it once the freeze lifts.
  always_comb begin
    status_d = status_q;
    if (bus.status_we && !bus.freeze) begin
      status_d = bus.status_in;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_wb_q <= '0;
      status_q <= '0;
    end else begin
      mem_wb_q <= mem_wb_d;
      status_q <= status_d;
    end
  end

  assign wb_value = mem_wb_q.r_en ? mem_wb_q.mem_data : mem_wb_q.alu_result;

  assign bus.wb_en_out    = mem_wb_q.wb_en;
  assign bus.wb_dest_out  = mem_wb_q.dest;
  assign bus.wb_value_out = wb_value;
  assign bus.status_out   = status_q;

  // Writes continue under freeze: the held entry just rewrites the same value.
  register_file u_register_file (
    .clk        (clk),
    .rst        (rst),
    .wb_en_i    (mem_wb_q.wb_en),
    .wb_dest_i  (mem_wb_q.dest),
    .wb_value_i (wb_value),
    .rd_addr1_i (bus.rd_addr1),
    .rd_addr2_i (bus.rd_addr2),
    .rd_data1_o (bus.rd_data1),
    .rd_data2_o (bus.rd_data2)
  );

endmodule
